// File: rtl/scoreboard_rob.sv
//------------------------------------------------------------------------------
// scoreboard_rob: circular in-order-allocate / out-of-order-complete /
// in-order-retire instruction tracker with multi-port completion and flush.
//------------------------------------------------------------------------------
`default_nettype none

module scoreboard_rob #(
    parameter int SCRBRD_SIZE  = 32,
    parameter int PC_WIDTH     = 32,
    parameter int OPCODE_WIDTH = 7,
    parameter int NUM_CMPL     = 2,
    localparam int IDXW        = $clog2(SCRBRD_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_alloc_vld,
    input  logic [PC_WIDTH-1:0]      i_alloc_pc,
    input  logic [OPCODE_WIDTH-1:0]  i_alloc_opcode,
    output logic                     o_alloc_rdy,
    output logic [IDXW-1:0]          o_alloc_idx,
    input  logic [NUM_CMPL-1:0]      i_cmpl_vld,
    input  logic [NUM_CMPL*IDXW-1:0] i_cmpl_idx,
    output logic                     o_retire_vld,
    input  logic                     i_retire_rdy,
    output logic [IDXW-1:0]          o_retire_idx,
    output logic [PC_WIDTH-1:0]      o_retire_pc,
    output logic [OPCODE_WIDTH-1:0]  o_retire_opcode,
    input  logic                     i_flush,
    output logic [IDXW:0]            o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam logic [IDXW:0]        c_SIZE_CNT = (IDXW+1)'(SCRBRD_SIZE);
    localparam logic [SCRBRD_SIZE-1:0] c_ONE    = SCRBRD_SIZE'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDXW:0]            r_head;
    logic [IDXW:0]            r_tail;
    logic [SCRBRD_SIZE-1:0]   r_vld;
    logic [SCRBRD_SIZE-1:0]   r_done;
    logic [PC_WIDTH-1:0]      r_pc  [SCRBRD_SIZE];
    logic [OPCODE_WIDTH-1:0]  r_opc [SCRBRD_SIZE];

    logic [IDXW-1:0]          w_head_idx;
    logic [IDXW-1:0]          w_tail_idx;
    logic [IDXW:0]            w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_alloc_fire;
    logic                     w_retire_vld;
    logic                     w_retire_fire;
    logic [SCRBRD_SIZE-1:0]   w_cmpl_hit;
    logic [SCRBRD_SIZE-1:0]   w_alloc_oh;
    logic [SCRBRD_SIZE-1:0]   w_ret_oh;
    logic [SCRBRD_SIZE-1:0]   w_vld_nxt;
    logic [SCRBRD_SIZE-1:0]   w_done_nxt;

    assign w_head_idx    = r_head[IDXW-1:0];
    assign w_tail_idx    = r_tail[IDXW-1:0];
    assign w_count       = r_tail - r_head;
    assign w_full        = (w_count == c_SIZE_CNT);
    assign w_empty       = (w_count == '0);
    assign w_alloc_fire  = i_alloc_vld & ~w_full;
    assign w_retire_vld  = ~w_empty & r_done[w_head_idx];
    assign w_retire_fire = w_retire_vld & i_retire_rdy;

    always_comb begin
        w_cmpl_hit = '0;
        for (int k = 0; k < NUM_CMPL; k++) begin
            if (i_cmpl_vld[k]) begin
                w_cmpl_hit[i_cmpl_idx[k*IDXW +: IDXW]] = 1'b1;
            end
        end
    end

    assign w_alloc_oh = w_alloc_fire  ? (c_ONE << w_tail_idx) : '0;
    assign w_ret_oh   = w_retire_fire ? (c_ONE << w_head_idx) : '0;

    // Completions only land on live entries; allocate and retire both clear done.
    assign w_vld_nxt  = (r_vld | w_alloc_oh) & ~w_ret_oh;
    assign w_done_nxt = (r_done | (w_cmpl_hit & r_vld)) & ~w_alloc_oh & ~w_ret_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_done <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_done <= '0;
        end else begin
            r_head <= r_head + (IDXW+1)'(w_retire_fire);
            r_tail <= r_tail + (IDXW+1)'(w_alloc_fire);
            r_vld  <= w_vld_nxt;
            r_done <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_fire && !i_flush) begin
            r_pc[w_tail_idx]  <= i_alloc_pc;
            r_opc[w_tail_idx] <= i_alloc_opcode;
        end
    end

    assign o_alloc_rdy     = ~w_full;
    assign o_alloc_idx     = w_tail_idx;
    assign o_retire_vld    = w_retire_vld;
    assign o_retire_idx    = w_head_idx;
    assign o_retire_pc     = r_pc[w_head_idx];
    assign o_retire_opcode = r_opc[w_head_idx];
    assign o_count         = w_count;
    assign o_full          = w_full;
    assign o_empty         = w_empty;

endmodule

`default_nettype wire
